round_sched: RTL and testbench
==============================

Name: round_sched

Overview:
- Schedules one shared rounding unit among NUM_REQ requesters, for example multiplier lanes or a divider.
- The rounding unit has 1-cycle registered latency: it samples data_in and round_mode on a clock edge, and data_out/acc are valid on the following cycle.
- round_sched arbitrates round-robin, drives the unit's inputs, tracks which requester owns the in-flight operation, and buffers results in a response FIFO with valid/ready backpressure.

Parameters:
- IS_DOUBLE, 0: 0 = single-precision widths (W_IN=48, W_OUT=24); 1 = double-precision widths (W_IN=106, W_OUT=53).
- NUM_REQ, 3: number of requesters, range 2..8.
- RSP_DEPTH, 4: response FIFO entries. Minimum 2; 3 or more is required for 1 result per cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*W_IN  packed unrounded products; slot i is bits [i*W_IN +: W_IN].
- req_mode  in  NUM_REQ*2  packed round modes: 00 toward zero, 01 toward +inf, 10 toward -inf, 11 nearest-even.
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens when req_valid[i] & req_ready[i].
- rnd_data_in  out  W_IN  to the rounding unit's data_in.
- rnd_mode  out  2  to the rounding unit's round_mode.
- rnd_rst  out  1  to the rounding unit's reset (active-high, synchronous); equals ~rst.
- rnd_data_out  in  W_OUT  from the rounding unit.
- rnd_acc  in  1  from the rounding unit's exact flag.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  clog2(NUM_REQ)  owner of the head result.
- rsp_data  out  W_OUT  rounded result.
- rsp_acc  out  1  1 = result was exact.
- busy  out  1  in-flight operation or FIFO non-empty.

Behaviour:
- Reset (rst low, asynchronous): rr_ptr = NUM_REQ-1, so requester 0 wins first; inflight_vld=0; FIFO count=0 and pointers=0.
  - During reset: req_ready=0, rsp_valid=0, busy=0. rsp_id, rsp_data and rsp_acc read 0.
  - rnd_rst=1 during reset, so the unit's stale output is never captured.
  - Reset mid-operation discards in-flight and queued results; no stale response appears after release.
- Credits: free = RSP_DEPTH - count - inflight_vld. A same-cycle pop is not counted, by design.
- Arbitration (combinational):
  - If free > 0, grant the first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready is all-zero when free == 0 or no request is valid.
  - req_ready never depends on rsp_ready.
- Issue cycle T, on handshake:
  - rnd_data_in and rnd_mode are muxed from the granted slot. When there is no grant they hold the slot-0 value; this is don't-care, because nothing is captured.
  - At the end-of-T edge: rr_ptr <= granted index, inflight_vld <= 1, inflight_id <= granted index.
  - With no handshake: inflight_vld <= 0 and rr_ptr holds.
- Capture cycle T+1: if inflight_vld, write {inflight_id, rnd_data_out, rnd_acc} to the FIFO tail at the end-of-T+1 edge.
- Response:
  - rsp_valid = (count != 0); head fields are driven combinationally from FIFO storage.
  - rsp_valid rises at cycle T+2, i.e. 2-cycle latency from handshake.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance and wrap modulo RSP_DEPTH.
- FIFO overflow cannot occur, because of the credit rule. A push into a full FIFO is an assertion failure.
- Ordering: responses leave in issue order. Throughput is 1 issue per cycle while free > 0.
- busy = inflight_vld | (count != 0).

Decomposition:
- Package round_pkg holds:
  - round-mode constants RM_RZ=2'b00, RM_RUP=2'b01, RM_RDN=2'b10, RM_RNE=2'b11;
  - width functions w_in(is_double) and w_out(is_double);
  - the response-entry width {id, data, acc}.
- One sub-module, round_rsp_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, asynchronous active-low reset.
- The arbiter and credit logic stay in round_sched. The rounding unit is instantiated by the parent, not inside round_sched.

Test Plan:
- Single request, nearest-even, rounds up:
  - Stimulus: IS_DOUBLE=0, req0 data 48'h000001_800000, mode 11, rsp_ready=1.
  - Required: req_ready[0]=1 in the same cycle; 2 cycles later rsp_valid=1 with rsp_id=0, rsp_data=24'h000002, rsp_acc=0.
- Exact input:
  - Stimulus: req1 data 48'h123456_000000, mode 01.
  - Required: rsp_data=24'h123456, rsp_acc=1, rsp_id=1.
- Round toward +inf with non-zero low part:
  - Stimulus: req2 data 48'h7FFFFF_000001, mode 01.
  - Required: rsp_data=24'h800000, rsp_acc=0.
- Round-robin fairness:
  - Stimulus: all 3 requesters held valid, rsp_ready=1.
  - Required: grants issue 0,1,2,0,1,2 on consecutive cycles; rsp_id follows the same order 2 cycles later.
- Backpressure:
  - Stimulus: rsp_ready=0, requesters continuously valid.
  - Required: exactly 4 handshakes (RSP_DEPTH), then req_ready=0. After rsp_ready=1, the 4 results pop in issue order and issuing resumes.
- Reset mid-operation:
  - Stimulus: drop rst while inflight_vld=1 and count=2.
  - Required: rsp_valid=0 and busy=0 immediately. After release, no response appears until a new handshake, and requester 0 is granted first.

Source files
------------

// File: rtl/round_pkg.sv
// Shared constants and width helpers for the round scheduler and its response FIFO.
package round_pkg;

    localparam logic [1:0] RM_RZ  = 2'b00;
    localparam logic [1:0] RM_RUP = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RNE = 2'b11;

    function automatic int w_in(input bit is_double);
        return is_double ? 106 : 48;
    endfunction

    function automatic int w_out(input bit is_double);
        return is_double ? 53 : 24;
    endfunction

    // Response entry is {id, data, acc}
    function automatic int rsp_w(input int id_w, input bit is_double);
        return id_w + w_out(is_double) + 1;
    endfunction

endpackage

// File: rtl/round_rsp_fifo.sv
// Synchronous FIFO holding rounded results until the consumer accepts them.
module round_rsp_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop & ~empty;
        wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        rdata = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head fields read zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/round_sched.sv
// Round-robin scheduler sharing one 1-cycle rounding unit among NUM_REQ requesters,
// with credit-based issue into a response FIFO.
module round_sched
    import round_pkg::*;
#(
    parameter  int IS_DOUBLE = 0,
    parameter  int NUM_REQ   = 3,
    parameter  int RSP_DEPTH = 4,
    localparam int W_IN      = w_in(IS_DOUBLE != 0),
    localparam int W_OUT     = w_out(IS_DOUBLE != 0),
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int E_W       = rsp_w(ID_W, IS_DOUBLE != 0),
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*W_IN-1:0] req_data,
    input  logic [NUM_REQ*2-1:0]    req_mode,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [W_IN-1:0]         rnd_data_in,
    output logic [1:0]              rnd_mode,
    output logic                    rnd_rst,
    input  logic [W_OUT-1:0]        rnd_data_out,
    input  logic                    rnd_acc,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [W_OUT-1:0]        rsp_data,
    output logic                    rsp_acc,
    output logic                    busy
);

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             inflight_vld_q, inflight_vld_d;
    logic [ID_W-1:0]  inflight_id_q, inflight_id_d;

    logic             has_credit;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  mux_idx;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [E_W-1:0]   fifo_head;

    always_comb begin
        int              idx_i;
        logic [ID_W-1:0] idx_c;
        idx_i      = 0;
        idx_c      = '0;
        // A pop in this cycle frees nothing until next cycle, keeping req_ready off rsp_ready.
        has_credit = !fifo_full &&
                     ((int'(fifo_count) + int'(inflight_vld_q)) < RSP_DEPTH);
        grant_vld  = 1'b0;
        grant_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_i = (int'(rr_ptr_q) + k) % NUM_REQ;
            idx_c = ID_W'(idx_i);
            if (!grant_vld && req_valid[idx_c]) begin
                grant_vld = 1'b1;
                grant_idx = idx_c;
            end
        end
        if (!has_credit || !rst) grant_vld = 1'b0;

        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;

        mux_idx     = grant_vld ? grant_idx : '0;
        rnd_data_in = req_data[int'(mux_idx)*W_IN +: W_IN];
        rnd_mode    = req_mode[int'(mux_idx)*2 +: 2];

        rr_ptr_d       = grant_vld ? grant_idx : rr_ptr_q;
        inflight_vld_d = grant_vld;
        inflight_id_d  = grant_vld ? grant_idx : inflight_id_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q       <= ID_W'(NUM_REQ - 1);
            inflight_vld_q <= 1'b0;
            inflight_id_q  <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            inflight_vld_q <= inflight_vld_d;
            inflight_id_q  <= inflight_id_d;
        end
    end

    round_rsp_fifo #(
        .WIDTH (E_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (inflight_vld_q),
        .wdata ({inflight_id_q, rnd_data_out, rnd_acc}),
        .pop   (rsp_valid & rsp_ready),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rnd_rst                     = ~rst;
    assign rsp_valid                   = ~fifo_empty;
    assign {rsp_id, rsp_data, rsp_acc} = fifo_head;
    assign busy                        = inflight_vld_q | ~fifo_empty;

endmodule

// File: tb/tb_round_sched.sv
// Bench for round_sched: behavioural rounding unit, vector table and scoreboard.
module tb_round_sched;
    import round_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int W_IN    = 48;
    localparam int W_OUT   = 24;
    localparam int ID_W    = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*W_IN-1:0] req_data;
    logic [NUM_REQ*2-1:0]    req_mode;
    logic [NUM_REQ-1:0]      req_ready;
    logic [W_IN-1:0]         rnd_data_in;
    logic [1:0]              rnd_mode;
    logic                    rnd_rst;
    logic [W_OUT-1:0]        rnd_data_out;
    logic                    rnd_acc;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [W_OUT-1:0]        rsp_data;
    logic                    rsp_acc;
    logic                    busy;

    round_sched #(.IS_DOUBLE(0), .NUM_REQ(NUM_REQ), .RSP_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .rnd_data_in  (rnd_data_in),
        .rnd_mode     (rnd_mode),
        .rnd_rst      (rnd_rst),
        .rnd_data_out (rnd_data_out),
        .rnd_acc      (rnd_acc),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_acc      (rsp_acc),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W_OUT:0] ref_round(input logic [W_IN-1:0] d, input logic [1:0] m);
        logic [W_OUT-1:0] hi, lo;
        logic inc;
        hi  = d[W_IN-1:W_OUT];
        lo  = d[W_OUT-1:0];
        inc = 1'b0;
        case (m)
            RM_RUP:  inc = (lo != '0);
            RM_RNE:  inc = (lo > 24'h800000) || ((lo == 24'h800000) && hi[0]);
            default: inc = 1'b0;
        endcase
        return {(lo == '0), W_OUT'(hi + W_OUT'(inc))};
    endfunction

    // Rounding unit: one registered stage, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rnd_rst) begin
            rnd_data_out <= '0;
            rnd_acc      <= 1'b0;
        end else begin
            {rnd_acc, rnd_data_out} <= ref_round(rnd_data_in, rnd_mode);
        end
    end

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [W_OUT-1:0] data;
        logic             acc;
    } exp_t;

    typedef struct {
        int               slot;
        logic [W_IN-1:0]  data;
        logic [1:0]       mode;
        logic [W_OUT-1:0] exp_data;
        logic             exp_acc;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   last_gnt;

    logic [NUM_REQ-1:0] s_ready;
    logic               s_rsp_valid;
    logic [ID_W-1:0]    s_id;
    logic [W_OUT-1:0]   s_data;
    logic               s_acc;
    logic               s_busy;
    logic [W_IN-1:0]    s_din;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge; outputs are sampled 1 ns later, then one clock passes.
    task automatic tick();
        exp_t e;
        #1;
        s_ready     = req_ready;
        s_rsp_valid = rsp_valid;
        s_id        = rsp_id;
        s_data      = rsp_data;
        s_acc       = rsp_acc;
        s_busy      = busy;
        s_din       = rnd_data_in;
        last_gnt    = -1;
        if (req_ready != '0) begin
            chk("grant_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    last_gnt = i;
                    hs_cnt++;
                    e.id = ID_W'(i);
                    {e.acc, e.data} = ref_round(req_data[i*W_IN +: W_IN], req_mode[i*2 +: 2]);
                    sb_q.push_back(e);
                end
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response", rsp_id, rsp_data);
            end else begin
                e = sb_q.pop_front();
                chk("sb_id", 64'(rsp_id), 64'(e.id));
                chk("sb_data", 64'(rsp_data), 64'(e.data));
                chk("sb_acc", 64'(rsp_acc), 64'(e.acc));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb_q.size() != 0; n++) tick();
        chk("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vt[0] = '{0, 48'h000001_800000, RM_RNE, 24'h000002, 1'b0};
        vt[1] = '{1, 48'h123456_000000, RM_RUP, 24'h123456, 1'b1};
        vt[2] = '{2, 48'h7FFFFF_000001, RM_RUP, 24'h800000, 1'b0};
        vt[3] = '{0, 48'h000002_800000, RM_RNE, 24'h000002, 1'b0};
        vt[4] = '{1, 48'h000003_800001, RM_RNE, 24'h000004, 1'b0};
        vt[5] = '{2, 48'h000005_FFFFFF, RM_RZ,  24'h000005, 1'b0};
        vt[6] = '{0, 48'h000005_000001, RM_RDN, 24'h000005, 1'b0};
        vt[7] = '{1, 48'hABCDEF_7FFFFF, RM_RNE, 24'hABCDEF, 1'b0};

        rst       = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*W_IN +: W_IN] = W_IN'({$urandom(), $urandom()});
            req_mode[i*2 +: 2]       = 2'($urandom_range(0, 3));
        end

        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_fields", 64'({rsp_id, rsp_data, rsp_acc}), 64'd0);
        chk("rst_rnd_rst", 64'(rnd_rst), 64'd1);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        chk("rnd_rst_release", 64'(rnd_rst), 64'd0);

        for (int v = 0; v < 8; v++) begin
            req_data[vt[v].slot*W_IN +: W_IN] = vt[v].data;
            req_mode[vt[v].slot*2 +: 2]       = vt[v].mode;
            req_valid = NUM_REQ'(1) << vt[v].slot;
            tick();
            chk("tv_ready", 64'(s_ready), 64'(NUM_REQ'(1) << vt[v].slot));
            chk("tv_rnd_din", 64'(s_din), 64'(vt[v].data));
            req_valid = '0;
            tick();
            chk("tv_lat_t1", 64'(s_rsp_valid), 64'd0);
            chk("tv_busy_t1", 64'(s_busy), 64'd1);
            tick();
            chk("tv_valid_t2", 64'(s_rsp_valid), 64'd1);
            chk("tv_id", 64'(s_id), 64'(vt[v].slot));
            chk("tv_data", 64'(s_data), 64'(vt[v].exp_data));
            chk("tv_acc", 64'(s_acc), 64'(vt[v].exp_acc));
        end
        tick();
        chk("idle_busy", 64'(s_busy), 64'd0);

        // Fresh reset so the pointer restarts and requester 0 wins first.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();

        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_grant", 64'(last_gnt), 64'(k % NUM_REQ));
        end
        req_valid = '0;
        drain();

        rsp_ready = 1'b0;
        req_valid = '1;
        hs_cnt    = 0;
        repeat (10) tick();
        chk("bp_handshakes", 64'(hs_cnt), 64'd4);
        chk("bp_ready_zero", 64'(s_ready), 64'd0);
        chk("bp_head_valid", 64'(s_rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        tick();
        chk("bp_no_same_cycle_credit", 64'(s_ready), 64'd0);
        tick();
        chk("bp_resume", 64'(s_ready != '0), 64'd1);
        req_valid = '0;
        drain();

        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        chk("mid_busy_before", 64'(s_busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_req_ready", 64'(req_ready), 64'd0);
        sb_q.delete();
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("post_rst_quiet", 64'(s_rsp_valid), 64'd0);
        end
        req_valid = '1;
        tick();
        chk("post_rst_first", 64'(s_ready), 64'd1);
        req_valid = '0;
        drain();
        tick();
        chk("final_busy", 64'(s_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
